// File: rtl/fifo_pkg.sv
// Shared constants for the 32-entry FIFO write-side and read-side control units.
package fifo_pkg;
  localparam int DEPTH    = 32;
  localparam int PTR_W    = 5;
  localparam int DATA_W   = 8;
  localparam int AF_LEVEL = 28;
  localparam int CNT_W    = PTR_W + 1;
endpackage

// File: rtl/fifo_occupancy_counter.sv
// Saturating up/down occupancy counter with full and almost-full decodes of the registered count.
module fifo_occupancy_counter
  import fifo_pkg::*;
#(
  parameter int DEPTH_P    = fifo_pkg::DEPTH,
  parameter int AF_LEVEL_P = fifo_pkg::AF_LEVEL,
  parameter int CNT_W_P    = fifo_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [CNT_W_P-1:0] count,
  output logic               full,
  output logic               almost_full
);

  localparam logic [CNT_W_P-1:0] MAX_C = CNT_W_P'(DEPTH_P);
  localparam logic [CNT_W_P-1:0] AF_C  = CNT_W_P'(AF_LEVEL_P);
  localparam logic [CNT_W_P-1:0] ONE_C = CNT_W_P'(1);

  logic [CNT_W_P-1:0] count_reg;
  logic [CNT_W_P-1:0] count_next;

  // Simultaneous inc and dec cancel; each direction saturates at its bound.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec && (count_reg != MAX_C)) begin
      count_next = count_reg + ONE_C;
    end else if (dec && !inc && (count_reg != '0)) begin
      count_next = count_reg - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count       = count_reg;
  assign full        = (count_reg == MAX_C);
  assign almost_full = (count_reg >= AF_C);

endmodule

// File: rtl/fifo_input_control.sv
// FIFO write-side controller: accepts producer writes, issues registered write strobes, tracks occupancy.
module fifo_input_control
  import fifo_pkg::*;
#(
  parameter int DEPTH    = fifo_pkg::DEPTH,
  parameter int PTR_W    = fifo_pkg::PTR_W,
  parameter int DATA_W   = fifo_pkg::DATA_W,
  parameter int AF_LEVEL = fifo_pkg::AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_done,
  output logic              write_en_o,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [DATA_W-1:0] data_o,
  output logic              overflow,
  output logic              full,
  output logic              almost_full,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE_PTR_C  = PTR_W'(1);

  logic              accept;
  logic              read_valid;

  logic [PTR_W-1:0]  head_reg,   head_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [DATA_W-1:0] data_reg,   data_next;
  logic              wen_reg,    wen_next;
  logic              ovf_reg,    ovf_next;

  // full/count come from the registered count, so accept has no path from outputs back to inputs.
  assign accept     = write_en && !full;
  assign read_valid = read_done && (count != '0);

  always_comb begin
    head_next   = head_reg;
    wr_ptr_next = wr_ptr_reg;
    data_next   = data_reg;
    wen_next    = 1'b0;
    ovf_next    = ovf_reg;
    if (accept) begin
      wen_next    = 1'b1;
      wr_ptr_next = head_reg;
      data_next   = data_in;
      head_next   = (head_reg == LAST_PTR_C) ? '0 : head_reg + ONE_PTR_C;
      ovf_next    = 1'b0;
    end else if (write_en) begin
      ovf_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg   <= '0;
      wr_ptr_reg <= '0;
      data_reg   <= '0;
      wen_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      head_reg   <= head_next;
      wr_ptr_reg <= wr_ptr_next;
      data_reg   <= data_next;
      wen_reg    <= wen_next;
      ovf_reg    <= ovf_next;
    end
  end

  fifo_occupancy_counter #(
    .DEPTH_P    (DEPTH),
    .AF_LEVEL_P (AF_LEVEL),
    .CNT_W_P    (PTR_W + 1)
  ) u_occupancy (
    .clk         (clk),
    .reset       (reset),
    .inc         (accept),
    .dec         (read_valid),
    .count       (count),
    .full        (full),
    .almost_full (almost_full)
  );

  assign write_en_o = wen_reg;
  assign wr_ptr     = wr_ptr_reg;
  assign data_o     = data_reg;
  assign overflow   = ovf_reg;

endmodule

// File: tb/tb_fifo_input_control.sv
// Directed bench for fifo_input_control: write-issue scoreboard plus per-cycle status checks.
module tb_fifo_input_control;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_done = 1'b0;
  logic       write_en_o;
  logic [4:0] wr_ptr;
  logic [7:0] data_o;
  logic       overflow;
  logic       full;
  logic       almost_full;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  // Expected write issues: {wr_ptr, data}
  logic [12:0] exp_q[$];

  int         m_count = 0;
  logic [4:0] m_head = '0;
  logic [4:0] m_ptr = '0;
  logic [7:0] m_data = '0;
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  fifo_input_control dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_done   (read_done),
    .write_en_o  (write_en_o),
    .wr_ptr      (wr_ptr),
    .data_o      (data_o),
    .overflow    (overflow),
    .full        (full),
    .almost_full (almost_full),
    .count       (count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every issued write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && write_en_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got ptr %0d data %02h expected no write", wr_ptr, data_o);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({wr_ptr, data_o} != e) begin
          errors++;
          $display("FAIL write_issue: got ptr %0d data %02h expected ptr %0d data %02h",
                   wr_ptr, data_o, e[12:8], e[7:0]);
        end else begin
          $display("write ptr=%0d data=%02h count=%0d", wr_ptr, data_o, count);
        end
      end
    end
  end

  task automatic check_status(input string tag, input logic exp_wen);
    chk({tag, "_write_en_o"}, int'(write_en_o), int'(exp_wen));
    chk({tag, "_wr_ptr"}, int'(wr_ptr), int'(m_ptr));
    chk({tag, "_data_o"}, int'(data_o), int'(m_data));
    chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, "_count"}, int'(count), m_count);
    chk({tag, "_full"}, int'(full), int'(m_count == 32));
    chk({tag, "_almost_full"}, int'(almost_full), int'(m_count >= 28));
  endtask

  // Drive one cycle of stimulus (inputs change at negedge) and check results one cycle later.
  task automatic step(input string tag, input logic we, input logic [7:0] d, input logic rd);
    logic acc, rv;
    acc = we && (m_count != 32);
    rv  = rd && (m_count != 0);
    if (acc) begin
      exp_q.push_back({m_head, d});
      m_ptr  = m_head;
      m_data = d;
      m_head = m_head + 5'd1;
      m_ovf  = 1'b0;
    end else if (we) begin
      m_ovf = 1'b1;
    end
    if (acc && !rv) m_count++;
    else if (rv && !acc) m_count--;
    write_en = we; data_in = d; read_done = rd;
    @(negedge clk);
    write_en = 1'b0; read_done = 1'b0;
    check_status(tag, acc);
  endtask

  task automatic model_reset();
    m_count = 0; m_head = '0; m_ptr = '0; m_data = '0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_status(tag, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #3;
    model_reset();
    check_status("por", 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Three writes
    step("w1", 1'b1, 8'hA1, 1'b0);
    step("w2", 1'b1, 8'hA2, 1'b0);
    step("w3", 1'b1, 8'hA3, 1'b0);

    // Fill from empty, then overflow, then write+read while full, then wrap
    do_reset("rst_fill");
    for (int i = 0; i < 32; i++) step("fill", 1'b1, 8'(8'h40 + i), 1'b0);
    step("w33", 1'b1, 8'hEE, 1'b0);
    step("idle_ovf_hold", 1'b0, 8'h00, 1'b0);
    step("full_wr_rd", 1'b1, 8'hDD, 1'b1);
    step("wrap", 1'b1, 8'h5A, 1'b0);

    // Read at empty is ignored; write+read at count 5 cancels
    do_reset("rst_empty");
    step("rd_empty", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, 8'(8'h10 + i), 1'b0);
    step("wr_rd_5", 1'b1, 8'h77, 1'b1);

    // Asynchronous reset mid-burst
    do_reset("rst_burst");
    for (int i = 0; i < 10; i++) step("burst", 1'b1, 8'(8'hC0 + i), 1'b0);
    write_en = 1'b1; data_in = 8'hCA;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_status("async_rst", 1'b0);
    write_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 1'b1, 8'h99, 1'b0);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_input_control.md
# fifo_input_control

Write-side controller of the 32-entry FIFO and the upstream counterpart of the read-side control unit. It accepts producer write requests with data and rejects writes when the FIFO is full. Accepted writes are registered and issued to the storage array as a write strobe, a 5-bit write pointer and data. It tracks occupancy from its own accepted writes and from read-completion pulses returned by the read side, and drives full, almost-full and overflow status.

## Interface
Parameters:
- DEPTH, 32, number of FIFO entries
- PTR_W, 5, pointer width (log2 DEPTH)
- DATA_W, 8, data word width
- AF_LEVEL, 28, occupancy at or above which almost_full asserts

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- write_en  in  1  producer write request, sampled each cycle
- data_in  in  DATA_W  producer data, valid with write_en
- read_done  in  1  one-cycle pulse from read side: one entry removed
- write_en_o  out  1  write strobe to storage array
- wr_ptr  out  PTR_W  storage address for the current write_en_o
- data_o  out  DATA_W  data for the current write_en_o
- overflow  out  1  last write request was rejected because the FIFO was full
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- count  out  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Internal state: head pointer (PTR_W bits), count (PTR_W+1 bits), overflow flag, output registers.
- accept = write_en && (count != DEPTH). Full is evaluated on the registered count.
- On accept:
  - write_en_o <= 1, wr_ptr <= head, data_o <= data_in.
  - head <= head + 1, wrapping modulo DEPTH (31 -> 0).
  - overflow <= 0.
- If write_en is high while full: write_en_o <= 0, overflow <= 1, and head, wr_ptr and data_o hold.
- If write_en is low: write_en_o <= 0 and overflow holds its value.
- read_valid = read_done && (count != 0). A read_done pulse at count 0 is ignored and count never underflows.
- Count update: accept only -> +1; read_valid only -> -1; both or neither -> unchanged.
- If the FIFO is full and write_en and read_done arrive in the same cycle, the write is rejected and overflow is set. The read still decrements count to DEPTH-1.
- full and almost_full are combinational decodes of the registered count. They carry no extra register stage.
- Reset values: write_en_o 0, wr_ptr 0, data_o 0, overflow 0, count 0, full 0, almost_full 0, head 0.

## Timing
- Latency from write_en to write_en_o, wr_ptr and data_o is 1 cycle.
- count, full and almost_full reflect a write or read one cycle after the request or pulse.
- Back-to-back writes sustain one write per cycle with consecutive wr_ptr values.
- An asynchronous reset assertion clears all state immediately. A write in flight is dropped and write_en_o falls without waiting for a clock edge.
- Deassert reset synchronously to clk. The first write is accepted on the first rising edge after deassertion.
- No combinational path from write_en or read_done to any output.

## Structure
- Package fifo_pkg holds:
  - Default constants: DEPTH, PTR_W, DATA_W and AF_LEVEL.
  - The localparam for count width (PTR_W+1), shared with the read-side control unit.
- One sub-module, fifo_occupancy_counter:
  - Up/down counter with inputs inc and dec.
  - Saturates at 0 and at DEPTH.
  - Outputs count, full and almost_full.
- The top level holds the head pointer, the overflow flag and the output registers.

## Test plan
- Reset, then 3 writes of 0xA1, 0xA2, 0xA3 -> wr_ptr 0, 1, 2 with write_en_o high for 3 cycles, count 3, overflow 0.
- 32 consecutive writes from empty:
  - almost_full rises when count reaches 28.
  - full rises when count reaches 32.
  - A 33rd write gives write_en_o 0 and overflow 1, and count stays 32.
- Full FIFO with write_en and read_done in the same cycle -> write rejected, overflow 1, count 31. The next write is accepted at wr_ptr 0 (wrap) and overflow clears.
- Empty FIFO with a read_done pulse -> count stays 0 and no other output changes. A simultaneous write at count 5 with read_done -> count stays 5.
- Reset asserted mid-burst after the 10th write -> all outputs go to 0 before the next edge. After deassertion the next write uses wr_ptr 0.
